// File: rtl/boot_host_uart_if.sv
// Host-side control bus of the boot upload/verify engine: image writes,
// run control and run status.
interface boot_host_uart_if;
  logic        img_we;
  logic [5:0]  img_adr;
  logic [15:0] img_din;
  logic        start;
  logic        verify;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  mismatch_cnt;

  modport master (
    output img_we, img_adr, img_din, start, verify,
    input  busy, done, err, mismatch_cnt
  );

  modport slave (
    input  img_we, img_adr, img_din, start, verify,
    output busy, done, err, mismatch_cnt
  );
endinterface

// File: rtl/boot_host_uart.sv
// Streams a 64x16 program image over UART 8N1 to the boot loader and can
// capture its scan dump back, counting words that differ from the image.
module boot_host_uart #(
  parameter int CLKS_PER_BIT = 87,
  parameter int GAP_BITS     = 2,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  boot_host_uart_if.slave host,
  output logic            tx,
  input  logic            rx,
  output logic            scan_req
);

  localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int TO_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW      = $clog2(((GAP_CYC > TO_CYC) ? GAP_CYC : TO_CYC) + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_RECV, S_FIN} state_t;

  state_t state, state_nx;

  logic [15:0]   image [64];
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [6:0]    byte_idx;
  logic [TW-1:0] timer;
  logic          verify_q;
  logic          rx_active;
  logic          rx_s1, rx_s2, rx_prev;
  logic          err_q;
  logic [6:0]    mis_q;
  logic [7:0]    rx_shift;
  logic [7:0]    hi_byte;

  logic [15:0]   cur_word;
  logic [7:0]    cur_byte;
  logic          tx_bit_val;
  logic          start_ok, bit_end, send_last, gap_end;
  logic          rx_fall, rx_half, frame_err, byte_ok, recv_last, timeout;

  // Same word index serves the outgoing byte and the incoming compare.
  assign cur_word  = image[byte_idx[6:1]];
  assign cur_byte  = byte_idx[0] ? cur_word[7:0] : cur_word[15:8];
  assign start_ok  = (state == S_IDLE) && host.start;
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign send_last = bit_end && (bit_idx == 4'd9) && (byte_idx == 7'd127);
  assign gap_end   = (timer == GAP_LAST);
  assign rx_fall   = !rx_active && rx_prev && !rx_s2;
  assign rx_half   = rx_active && (bit_cnt == BIT_HALF);
  assign frame_err = rx_half && (bit_idx == 4'd9) && !rx_s2;
  assign byte_ok   = rx_half && (bit_idx == 4'd9) && rx_s2;
  assign recv_last = byte_ok && (byte_idx == 7'd127);
  assign timeout   = !rx_active && !rx_fall && (timer == TO_LAST);

  always_comb begin
    tx_bit_val = 1'b1;
    case (bit_idx)
      4'd0:    tx_bit_val = 1'b0;
      4'd9:    tx_bit_val = 1'b1;
      default: tx_bit_val = cur_byte[3'(bit_idx - 4'd1)];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)  state <= S_IDLE;
    else if (ce) state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (host.start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_SEND;
      S_SEND: if (send_last) state_nx = verify_q ? S_GAP : S_FIN;
      S_GAP:  if (gap_end) state_nx = S_RECV;
      S_RECV: if (frame_err || recv_last || timeout) state_nx = S_FIN;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx        = 1'b1;
    host.busy = 1'b0;
    host.done = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LOAD: host.busy = 1'b1;
      S_SEND: begin
        host.busy = 1'b1;
        tx        = tx_bit_val;
      end
      S_GAP:  host.busy = 1'b1;
      S_RECV: host.busy = 1'b1;
      S_FIN:  host.done = 1'b1;
      default: ;
    endcase
  end

  assign host.err          = err_q;
  assign host.mismatch_cnt = mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      timer     <= '0;
      verify_q  <= 1'b0;
      rx_active <= 1'b0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      scan_req  <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= '0;
    end else if (ce) begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      unique case (state)
        S_IDLE: if (start_ok) begin
          verify_q <= host.verify;
          err_q    <= 1'b0;
          mis_q    <= '0;
        end
        S_LOAD: begin
          bit_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          timer    <= '0;
        end
        S_SEND: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx  <= '0;
              byte_idx <= byte_idx + 7'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_GAP: begin
          byte_idx  <= '0;
          rx_active <= 1'b0;
          timer     <= gap_end ? '0 : timer + TW'(1);
          if (gap_end) scan_req <= 1'b1;
        end
        S_RECV: begin
          if (!rx_active) begin
            // Idle timer only runs while waiting for a start bit.
            if (rx_fall) begin
              rx_active <= 1'b1;
              bit_cnt   <= '0;
              bit_idx   <= '0;
              timer     <= '0;
            end else if (timeout) begin
              err_q    <= 1'b1;
              scan_req <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            if (bit_end) begin
              bit_cnt <= '0;
              bit_idx <= bit_idx + 4'd1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
            if (rx_half && (bit_idx == 4'd0) && rx_s2) rx_active <= 1'b0;
            if (rx_half && (bit_idx == 4'd9)) begin
              rx_active <= 1'b0;
              if (!rx_s2) begin
                err_q <= 1'b1;
              end else begin
                scan_req <= 1'b0;
                byte_idx <= byte_idx + 7'd1;
                if (byte_idx[0] && ({hi_byte, rx_shift} != cur_word))
                  mis_q <= mis_q + 7'd1;
              end
            end
          end
        end
        S_FIN: scan_req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Image store and receive shifter carry no reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (rst_n && (state == S_IDLE) && host.img_we)
        image[host.img_adr] <= host.img_din;
      if ((state == S_RECV) && rx_half && (bit_idx != 4'd0) && (bit_idx != 4'd9))
        rx_shift <= {rx_s2, rx_shift[7:1]};
      if ((state == S_RECV) && byte_ok && !byte_idx[0])
        hi_byte <= rx_shift;
    end
  end

endmodule

// File: tb/tb_boot_host_uart.sv
// Directed bench for boot_host_uart: upload, verify, error paths, reset and ce.
module tb_boot_host_uart;

  localparam int CPB      = 4;
  localparam int UP_LAT   = 1 + 1280 * CPB;
  localparam int SCAN_LAT = UP_LAT + 2 * CPB;
  localparam int TO_LAT   = SCAN_LAT + 64 * CPB;

  logic clk = 1'b0;
  logic rst_n, ce, rx;
  logic tx, scan_req;

  boot_host_uart_if bus();

  boot_host_uart #(.CLKS_PER_BIT(CPB), .GAP_BITS(2), .TIMEOUT_BITS(64)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .host(bus),
    .tx(tx), .rx(rx), .scan_req(scan_req)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] img [64];

  // Decoder for the DUT tx line; counts only ce-qualified cycles.
  logic       mon_en = 1'b0;
  logic       m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] mon_q [$];
  int         mon_ferr = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      m_act = 1'b0;
      m_cnt = 0;
      mon_q.delete();
      mon_ferr = 0;
    end else if (ce) begin
      if (!m_act) begin
        if (tx == 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt % CPB == CPB / 2) begin
          if (m_cnt / CPB >= 1 && m_cnt / CPB <= 8) begin
            m_sh[m_cnt / CPB - 1] = tx;
          end else if (m_cnt / CPB == 9) begin
            if (tx !== 1'b1) mon_ferr++;
            mon_q.push_back(m_sh);
            m_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_restart();
    mon_en = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic run_start(input logic v);
    bus.verify = v;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stopv;
    repeat (CPB) tick();
  endtask

  task automatic load_image();
    for (int i = 0; i < 64; i++) img[i] = 16'(i * 2621) ^ 16'h6C21;
    img[0]  = 16'hA55A;
    img[1]  = 16'h1235;
    img[63] = 16'h0001;
    for (int i = 0; i < 64; i++) begin
      bus.img_we  = 1'b1;
      bus.img_adr = 6'(i);
      bus.img_din = img[i];
      tick();
    end
    bus.img_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    rx = 1'b1;
    bus.img_we = 1'b0;
    bus.img_adr = '0;
    bus.img_din = '0;
    bus.start = 1'b0;
    bus.verify = 1'b0;
    tick();
    tick();
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
    vectors++; if (bus.mismatch_cnt !== 7'd0) begin miscompares++; $display("FAIL reset_mismatch got %0d want 0", bus.mismatch_cnt); end
    vectors++; if (scan_req !== 1'b0) begin miscompares++; $display("FAIL reset_scan_req got %b want 0", scan_req); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_upload();
    int cnt;
    load_image();
    mon_restart();
    run_start(1'b0);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < UP_LAT + 200) begin tick(); cnt++; end
    vectors++; if (cnt !== UP_LAT) begin miscompares++; $display("FAIL upload_latency got %0d want %0d", cnt, UP_LAT); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL upload_busy_at_done got %b want 0", bus.busy); end
    vectors++; if (mon_q.size() !== 128) begin miscompares++; $display("FAIL upload_byte_count got %0d want 128", mon_q.size()); end
    vectors++; if (mon_q[0] !== 8'hA5) begin miscompares++; $display("FAIL upload_byte0 got %h want a5", mon_q[0]); end
    vectors++; if (mon_q[1] !== 8'h5A) begin miscompares++; $display("FAIL upload_byte1 got %h want 5a", mon_q[1]); end
    vectors++; if (mon_q[126] !== 8'h00) begin miscompares++; $display("FAIL upload_byte126 got %h want 00", mon_q[126]); end
    vectors++; if (mon_q[127] !== 8'h01) begin miscompares++; $display("FAIL upload_byte127 got %h want 01", mon_q[127]); end
    vectors++; if (mon_ferr !== 0) begin miscompares++; $display("FAIL upload_stop_bits got %0d bad want 0", mon_ferr); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL upload_err got %b want 0", bus.err); end
    tick();
  endtask

  task automatic test_verify(input int flip_a, input int flip_b, input int want_mis, input string tag);
    int cnt;
    logic [15:0] w;
    run_start(1'b1);
    cnt = 0;
    while (scan_req !== 1'b1 && cnt < SCAN_LAT + 200) begin tick(); cnt++; end
    vectors++; if (cnt !== SCAN_LAT) begin miscompares++; $display("FAIL %s_scan_rise got %0d want %0d", tag, cnt, SCAN_LAT); end
    for (int i = 0; i < 64; i++) begin
      w = img[i];
      if (i == flip_a || i == flip_b) w[0] = ~w[0];
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
      if (i == 0) begin
        vectors++; if (scan_req !== 1'b0) begin miscompares++; $display("FAIL %s_scan_drop got %b want 0", tag, scan_req); end
      end
    end
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL %s_done got %b want 1", tag, bus.done); end
    vectors++; if (bus.mismatch_cnt !== 7'(want_mis)) begin miscompares++; $display("FAIL %s_mismatch got %0d want %0d", tag, bus.mismatch_cnt, want_mis); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL %s_err got %b want 0", tag, bus.err); end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    run_start(1'b1);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < TO_LAT + 200) begin tick(); cnt++; end
    vectors++; if (cnt !== TO_LAT) begin miscompares++; $display("FAIL timeout_latency got %0d want %0d", cnt, TO_LAT); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL timeout_err got %b want 1", bus.err); end
    vectors++; if (scan_req !== 1'b0) begin miscompares++; $display("FAIL timeout_scan_req got %b want 0", scan_req); end
    tick();
  endtask

  task automatic test_stop_error();
    int cnt;
    run_start(1'b1);
    cnt = 0;
    while (scan_req !== 1'b1 && cnt < SCAN_LAT + 200) begin tick(); cnt++; end
    send_byte(img[0][15:8], 1'b0);
    rx = 1'b1;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL stoperr_done got %b want 1", bus.done); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL stoperr_err got %b want 1", bus.err); end
    tick();
  endtask

  task automatic test_reset_and_ce();
    int cnt;
    int n;
    mon_restart();
    run_start(1'b0);
    cnt = 0;
    while (mon_q.size() < 10 && cnt < 2000) begin tick(); cnt++; end
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midreset_tx got %b want 1", tx); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL midreset_err got %b want 0", bus.err); end
    rst_n = 1'b1;
    mon_restart();
    tick();
    run_start(1'b0);
    cnt = 0;
    while (mon_q.size() < 3 && cnt < 1000) begin tick(); cnt++; end
    while (tx !== 1'b0 && cnt < 1000) begin tick(); cnt++; end
    n = 0;
    while (tx === 1'b0 && n < 300) begin
      n++;
      if (n == 3) ce = 1'b0;
      if (n == 53) ce = 1'b1;
      tick();
      cnt++;
    end
    ce = 1'b1;
    vectors++; if (n !== CPB + 50) begin miscompares++; $display("FAIL ce_stretch got %0d want %0d", n, CPB + 50); end
    while (bus.done !== 1'b1 && cnt < UP_LAT + 400) begin tick(); cnt++; end
    vectors++; if (cnt !== UP_LAT + 50) begin miscompares++; $display("FAIL ce_latency got %0d want %0d", cnt, UP_LAT + 50); end
    vectors++; if (mon_q.size() !== 128) begin miscompares++; $display("FAIL resend_count got %0d want 128", mon_q.size()); end
    vectors++; if (mon_q[0] !== 8'hA5) begin miscompares++; $display("FAIL resend_byte0 got %h want a5", mon_q[0]); end
    vectors++; if (mon_q[1] !== 8'h5A) begin miscompares++; $display("FAIL resend_byte1 got %h want 5a", mon_q[1]); end
    vectors++; if (mon_q[3] !== 8'h35) begin miscompares++; $display("FAIL ce_byte3 got %h want 35", mon_q[3]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_upload();
    test_verify(-1, -1, 0, "verify_pass");
    test_verify(3, 40, 2, "verify_corrupt");
    test_timeout();
    test_stop_error();
    test_reset_and_ce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_host_uart.md
Name: boot_host_uart

Overview:
- Host-side counterpart of the CPU boot loader.
- Holds a 64x16 program image and streams it over UART 8N1 into the boot loader rx pin.
- Optionally raises the scan request, captures the boot loader's tx dump and compares it word by word against the image.
- Used as the upload/verify engine in the FPGA harness and in system testbenches.

Parameters:
- CLKS_PER_BIT, 87: clock-enabled cycles per UART bit (10 MHz / 115200).
- GAP_BITS, 2: idle bit-times inserted between upload end and scan request.
- TIMEOUT_BITS, 64: bit-times allowed in RECV with no start bit before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- ce  in  1  clock enable; when 0 all state holds
- img_we  in  1  image write strobe (accepted only in IDLE)
- img_adr  in  6  image write address
- img_din  in  16  image write data
- start  in  1  single-cycle pulse; begins upload (accepted only in IDLE)
- verify  in  1  sampled with start; 1 = run scan and compare after upload
- tx  out  1  UART line to boot loader rx, idle high
- rx  in  1  UART line from boot loader tx (asynchronous)
- scan_req  out  1  drives boot loader scan_memory
- busy  out  1  high from start acceptance until done
- done  out  1  single-cycle pulse at end of run
- err  out  1  sticky until next start: framing error or timeout
- mismatch_cnt  out  7  number of words differing in last verify (0..64)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active low on rst_n. All actions are qualified by ce=1, and ce=0 freezes every counter and the FSM.
- Reset values: tx=1, scan_req=0, busy=0, done=0, err=0, mismatch_cnt=0, FSM=IDLE. The image contents are not reset.
- Reset mid-transfer: state and outputs return to the reset values on the next clk edge. tx goes high even if a frame is mid-bit.
- Byte order: 128 bytes, word 0 first, high byte before low byte within each word.
- UART framing: 8N1, LSB first. Each frame is 1 start bit (0), 8 data bits, then 1 stop bit (1), each bit lasting CLKS_PER_BIT cycles. Frames are sent back to back with no idle gap between them.
- IDLE:
  - img_we writes image[img_adr] <= img_din.
  - start=1 latches verify, clears err and mismatch_cnt, sets busy next cycle, and goes to SEND.
- SEND:
  - Transmits 128 bytes.
  - tx start bit begins the cycle after busy rises.
  - After the last stop bit: go to GAP if verify=1, otherwise go to FIN.
- GAP:
  - Holds tx=1 for GAP_BITS*CLKS_PER_BIT cycles.
  - Then sets scan_req=1 and goes to RECV.
- RECV:
  - rx passes through a 2-flop synchronizer. A falling edge starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If rx is high there, the frame is discarded as a glitch.
  - Data bits are sampled at bit centres.
  - If the stop bit samples 0: set err and go to FIN.
  - scan_req drops to 0 on the first valid received byte.
  - Each received byte pair is assembled high-then-low and compared to image[word]. mismatch_cnt increments on inequality.
  - After 128 bytes, go to FIN.
  - Timeout: if the idle time with no start bit exceeds TIMEOUT_BITS*CLKS_PER_BIT cycles, set err, clear scan_req, and go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE. mismatch_cnt and err hold until the next accepted start.
- Busy-time inputs: start and img_we are ignored while busy. rx activity outside RECV is ignored.
- Latency: the upload-only run takes 1 + 1280*CLKS_PER_BIT cycles from start to the done pulse (ce held high).

Test Plan:
- Reset → idle: CLKS_PER_BIT=4. Hold rst_n=0 for 2 cycles → tx=1, busy=0, err=0, mismatch_cnt=0.
- Upload only, first frame: load image[0]=16'hA55A and image[63]=16'h0001, pulse start with verify=0. Required: the bit monitor decodes bytes 5A-order-correct as A5 then 5A first.
- Upload only, completion: in the same run, bytes 00, 01 come last, and done pulses exactly 1+1280*4 cycles after start.
- Verify pass: loopback model echoes the image after seeing scan_req=1 → done, mismatch_cnt=0, err=0, scan_req low after first byte.
- Verify with corruption: model flips bit 0 of words 3 and 40 → mismatch_cnt=2, err=0.
- Error paths:
  - Model never responds → err=1 and done after GAP + TIMEOUT_BITS*4 cycles, scan_req=0.
  - Model sends a stop bit of 0 → err=1.
- Reset mid-SEND and ce gating:
  - Drop rst_n during byte 10 → tx=1 and busy=0 next cycle, and a subsequent start re-sends from byte 0.
  - ce low for 50 cycles mid-frame stretches that bit by exactly 50 cycles.
